// File: rtl/montacargas_input_conditioner.sv
// Synchronizes and debounces lift call buttons, door switch and floor limit switches.
// Build option MONTACARGAS_CALL_LATCH_EN: hold call requests until the cabin reaches the floor.
module montacargas_input_conditioner #(
  parameter int DEBOUNCE_TICKS = 3,
  parameter int CNT_W          = 4
) (
  input  logic clockBase_4MHz,
  input  logic reset,
  input  logic clockInt_150Hz,
  input  logic btnP1,
  input  logic btnP2,
  input  logic btnP3,
  input  logic swSPC,
  input  logic swFC1,
  input  logic swFC2,
  input  logic swFC3,
  output logic P1,
  output logic P2,
  output logic P3,
  output logic SPC,
  output logic FC1,
  output logic FC2,
  output logic FC3,
  output logic sensorError,
  output logic tick150
);

  localparam int NCH = 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  // Channel order: 0..2 buttons P1..P3, 3 door, 4..6 limit switches FC1..FC3, 7 = 150 Hz.
  logic [NCH:0]     raw;
  logic [NCH:0]     sync1_q;
  logic [NCH:0]     sync2_q;
  logic             tick_prev_q;
  logic             tick_q;
  logic             tick_d;
  logic [NCH-1:0]   deb_q;
  logic [NCH-1:0]   deb_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic             err_q;
  logic             err_d;
  logic [2:0]       p_req;

  assign raw = {clockInt_150Hz, swFC3, swFC2, swFC1, swSPC, btnP3, btnP2, btnP1};

  assign tick_d = sync2_q[NCH] & ~tick_prev_q;
  assign err_d  = (deb_q[4] & deb_q[5]) | (deb_q[4] & deb_q[6]) | (deb_q[5] & deb_q[6]);

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick_q) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = ~deb_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clockBase_4MHz) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      tick_prev_q <= 1'b0;
      tick_q      <= 1'b0;
      deb_q       <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      tick_prev_q <= sync2_q[NCH];
      tick_q      <= tick_d;
      deb_q       <= deb_d;
      err_q       <= err_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef MONTACARGAS_CALL_LATCH_EN
  logic [2:0] call_q;
  logic [2:0] call_d;

  // Arrival at the floor and a sensor fault both override a pending or new request.
  assign call_d = (call_q | deb_q[2:0]) & ~deb_q[6:4] & {3{~err_d}};

  always_ff @(posedge clockBase_4MHz) begin
    if (reset) call_q <= '0;
    else       call_q <= call_d;
  end

  assign p_req = call_q;
`else
  assign p_req = deb_q[2:0];
`endif

  assign {P3, P2, P1}    = p_req & {3{~err_q}};
  assign SPC             = deb_q[3];
  assign {FC3, FC2, FC1} = deb_q[6:4];
  assign sensorError     = err_q;
  assign tick150         = tick_q;

endmodule
